// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - GPR write-port arbiter: ALU priority, long-path FIFO, pending scoreboard
module gpr_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_we,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic [31:0] sb_busy,
  output logic [4:0]  wr_addr,
  output logic        we,
  output logic [31:0] wr_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

  logic [4:0]    addr_mem_q [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   sb_q, sb_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;
  logic          alu_sel, pop, push;

  // Gating with rst_n drops the write port the instant reset asserts.
  assign alu_sel  = rst_n && alu_we && (alu_addr != 5'd0);
  assign pop      = !alu_sel && (count_q != '0);
  assign lu_ready = (count_q < DEPTH_C);
  assign push     = lu_valid && lu_ready && (lu_addr != 5'd0);

  always_comb begin
    we      = 1'b0;
    wr_addr = 5'd0;
    wr_data = 32'd0;
    if (alu_sel) begin
      we      = 1'b1;
      wr_addr = alu_addr;
      wr_data = alu_data;
    end else if (pop) begin
      we      = 1'b1;
      wr_addr = addr_mem_q[head_q];
      wr_data = data_mem_q[head_q];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) head_d = head_q + AW'(1);
    if (push) tail_d = tail_q + AW'(1);
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Set after clear so a same-cycle issue wins over the drain.
  always_comb begin
    sb_d = sb_q;
    if (pop) sb_d[addr_mem_q[head_q]] = 1'b0;
    if (iss_valid && (iss_addr != 5'd0)) sb_d[iss_addr] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (pop || (count_q == '0)) begin
      starve_d = '0;
    end else if (alu_sel && (starve_q < SMAX_C)) begin
      starve_d = starve_q + SW'(1);
    end
    if (pop) stall_d = 1'b0;
    else if (starve_d == SMAX_C) stall_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      sb_q     <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      sb_q     <= sb_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[tail_q] <= lu_addr;
      data_mem_q[tail_q] <= lu_data;
    end
  end

  assign sb_busy   = sb_q;
  assign alu_stall = stall_q;

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Write-side driver for the 32x32 GPR file: produces its single write port (wr_addr/we/wr_data) from two result sources.
- Sources: the single-cycle ALU (fixed priority, never back-pressured) and a multi-cycle unit (load/mul-div) with valid/ready handshake, buffered in a small FIFO.
- Keeps a 32-bit pending-destination scoreboard for issue-stage interlock.
- Bounds ALU starvation of the FIFO with a stall request.

Parameters:
- DEPTH, 2, long-path FIFO entries (power of two, >=2).
- STARVE_MAX, 4, consecutive cycles in which the ALU blocks a non-empty FIFO before alu_stall is raised.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- alu_we  in  1  ALU result valid this cycle.
- alu_addr  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_stall  out  1  registered; upstream must hold alu_we=0 while high.
- lu_valid  in  1  long-path result valid.
- lu_ready  out  1  long-path accept; equals (count < DEPTH).
- lu_addr  in  5  long-path destination register.
- lu_data  in  32  long-path result.
- iss_valid  in  1  long-latency op issued this cycle.
- iss_addr  in  5  its destination register.
- sb_busy  out  32  pending-destination bit vector; bit 0 is always 0.
- wr_addr  out  5  to GPR write address.
- we  out  1  to GPR write enable.
- wr_data  out  32  to GPR write data.

Behaviour:
- Reset: asynchronous on rst_n low. Clears the FIFO (head/tail/count=0), sb_busy=0, starve counter=0 and alu_stall=0. lu_ready=1 after reset. we=0 and wr_addr/wr_data=0 while idle.
- Write-port mux (combinational, same cycle):
  - alu_we && alu_addr!=0 selects the ALU.
  - Otherwise, if count>0, selects the FIFO head and pops it (drain).
  - Otherwise we=0, addr/data=0.
  - An ALU write to r0 is dropped and frees the slot for a drain.
- Latency: ALU result reaches the write port in 0 cycles. A long-path result enters the FIFO at the accept edge and reaches the write port at the earliest one cycle later.
- Long-path accept: on lu_valid && lu_ready. lu_ready does not depend on a same-cycle pop, so a full FIFO is not ready even while draining.
  - lu_addr==0: the handshake completes, nothing is enqueued, and sb_busy is unaffected.
- FIFO: circular, DEPTH entries of {addr, data}. Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged. count ranges 0..DEPTH.
- Scoreboard:
  - iss_valid && iss_addr!=0 sets sb_busy[iss_addr] at the next edge.
  - A FIFO drain to register r clears sb_busy[r].
  - Set and clear of the same bit in the same cycle: set wins.
  - ALU writes never touch sb_busy.
  - Upstream guarantees no second issue to a busy register; no counting per register.
- Starvation counter:
  - Increments on each cycle with count>0 and an ALU write occupying the port.
  - Resets to 0 on any drain or when count==0.
  - alu_stall is registered high when the counter reaches STARVE_MAX, and stays high until a drain occurs; it clears at the edge after the drain.
  - If alu_we is asserted despite alu_stall, the ALU still wins and no result is lost; the counter saturates at STARVE_MAX.
- Reset mid-operation: FIFO contents and pending bits are discarded. There is no partial write: we falls to 0 immediately.

Test Plan:
1. Reset, then alu_we=1, addr=5, data=0x1234 for 1 cycle -> same cycle we=1, wr_addr=5, wr_data=0x1234; sb_busy=0.
2. iss addr=7, then 3 cycles later lu_valid, addr=7, data=0xDEAD with ALU idle -> sb_busy[7]=1 from the cycle after issue. Next cycle: we=1, addr=7, data=0xDEAD. sb_busy[7]=0 on the following edge.
3. ALU writes continuously to r1..r9 while 2 long results are pushed -> lu_ready=0 once count=2. alu_stall rises after 4 blocked cycles. With alu_we dropped, the entry in FIFO order is written and alu_stall clears next edge.
4. FIFO full and draining with lu_valid held -> lu_ready stays 0 that cycle; the push is accepted the following cycle. Pointers wrap correctly over 10 push/pop pairs, with data order preserved.
5. alu_we=1, addr=0, concurrently with FIFO head {3, 0xA5A5} -> drain wins: we=1, addr=3. iss_addr=0 and lu_addr=0 leave sb_busy[0]=0.
6. Drain of r4 in the same cycle as iss_valid, addr=4 -> sb_busy[4]=1. Assert rst_n=0 with count=2 -> count=0, sb_busy=0 and we=0 immediately.
